// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM.
//
// Contents:
//   - State encodings (4-bit, codes 12-15 unused)
//   - Opcode and funct field constants
//   - ALUControl codes and ALU-op class codes
//   - ctrl_t: packed bundle of the single-bit and select control outputs
//   - is_mem_op(): true for lw/sw opcodes
package mips_pkg;

  // State encodings (fixed; software/debug depends on them)
  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecute  = 4'd6;
  localparam logic [3:0] StAluWb    = 4'd7;
  localparam logic [3:0] StBranch   = 4'd8;
  localparam logic [3:0] StAddiExec = 4'd9;
  localparam logic [3:0] StAddiWb   = 4'd10;
  localparam logic [3:0] StJump     = 4'd11;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALUControl codes
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALU-op classes handed from the FSM to the ALU decoder.
  // AluOpNone is used by states that do not use the ALU; it yields 000.
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;
  localparam logic [1:0] AluOpNone  = 2'b11;

  // PCSrc / ALUSrcB select values
  localparam logic [1:0] PcSrcAluResult = 2'b00;
  localparam logic [1:0] PcSrcAluOut    = 2'b01;
  localparam logic [1:0] PcSrcJump      = 2'b10;

  localparam logic [1:0] SrcBRt       = 2'b00;
  localparam logic [1:0] SrcBFour     = 2'b01;
  localparam logic [1:0] SrcBSignExt  = 2'b10;
  localparam logic [1:0] SrcBSignExt2 = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       branch;
    logic       alu_src_a;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

endpackage

// File: rtl/mips_main_fsm_if.sv
// Control bus between the main FSM and the multicycle datapath.
//
// Signals:
//   opcode, funct      : instruction fields from the instruction register
//   IorD ... ALUSrcA   : single-bit datapath controls
//   PCSrc, ALUSrcB     : 2-bit selects
//   ALUControl         : 3-bit ALU operation
//   state, illegal_op  : debug state and unsupported-opcode flag
// Modports:
//   slave  : the FSM (consumes opcode/funct, drives controls)
//   master : the datapath / bench (drives opcode/funct, consumes controls)
interface mips_main_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       IorD;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       Branch;
  logic       ALUSrcA;
  logic [1:0] PCSrc;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic       illegal_op;

  modport slave (
    input  opcode, funct,
    output IorD, MemWrite, MemtoReg, IRWrite, PCWrite, RegWrite, RegDst, Branch,
           ALUSrcA, PCSrc, ALUSrcB, ALUControl, state, illegal_op
  );

  modport master (
    output opcode, funct,
    input  IorD, MemWrite, MemtoReg, IRWrite, PCWrite, RegWrite, RegDst, Branch,
           ALUSrcA, PCSrc, ALUSrcB, ALUControl, state, illegal_op
  );
endinterface

// File: rtl/mips_alu_dec.sv
// ALU decoder: maps the FSM's ALU-op class plus the R-type funct field to
// a 3-bit ALUControl code.
//
// Ports:
//   alu_op     in  2  00 add, 01 sub, 10 decode funct, 11 unused (000)
//   funct      in  6  instr[5:0]
//   ALUControl out 3  ALU operation
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = AluAnd;
    case (alu_op)
      AluOpAdd: ALUControl = AluAdd;
      AluOpSub: ALUControl = AluSub;
      AluOpFunct: begin
        case (funct)
          FnAdd:   ALUControl = AluAdd;
          FnSub:   ALUControl = AluSub;
          FnAnd:   ALUControl = AluAnd;
          FnOr:    ALUControl = AluOr;
          FnSlt:   ALUControl = AluSlt;
          default: ALUControl = AluAdd;
        endcase
      end
      default: ALUControl = AluAnd;
    endcase
  end

endmodule

// File: rtl/mips_main_fsm.sv
// Main control FSM of a multicycle MIPS processor (lw, sw, R-type, beq, j,
// and optionally addi). Moore machine: all controls derive from the state
// register; ALUControl additionally follows funct in EXECUTE, and
// illegal_op flags the DECODE cycle of an unsupported opcode.
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset (forces FETCH)
//   bus  mips_main_fsm_if.slave  opcode/funct in, controls/state/illegal_op out
//
// Configuration:
//   MIPS_FSM_ADDI_EN  defined   -> addi via ADDIEXEC/ADDIWB
//                     undefined -> opcode 001000 is illegal
module mips_main_fsm
  import mips_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mips_main_fsm_if.slave bus
);

  logic [3:0] r_state;
  logic [3:0] w_state_next;
  logic       w_illegal;
  ctrl_t      w_ctrl;
  logic [1:0] w_alu_op;
  logic [2:0] w_alu_control;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = StFetch;
    w_illegal    = 1'b0;
    case (r_state)
      StFetch: w_state_next = StDecode;
      StDecode: begin
        if (is_mem_op(bus.opcode)) begin
          w_state_next = StMemAdr;
        end else begin
          case (bus.opcode)
            OpRtype: w_state_next = StExecute;
            OpBeq:   w_state_next = StBranch;
`ifdef MIPS_FSM_ADDI_EN
            OpAddi:  w_state_next = StAddiExec;
`endif
            OpJ:     w_state_next = StJump;
            default: begin
              w_state_next = StFetch;
              w_illegal    = 1'b1;
            end
          endcase
        end
      end
      StMemAdr: begin
        // Opcode is held by the IR for the whole instruction.
        if (bus.opcode == OpLw) begin
          w_state_next = StMemRead;
        end else if (bus.opcode == OpSw) begin
          w_state_next = StMemWrite;
        end else begin
          w_state_next = StFetch;
        end
      end
      StMemRead:  w_state_next = StMemWb;
      StExecute:  w_state_next = StAluWb;
`ifdef MIPS_FSM_ADDI_EN
      StAddiExec: w_state_next = StAddiWb;
`endif
      // MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP and unused codes
      default:    w_state_next = StFetch;
    endcase
  end

  // Output logic (Moore)
  always_comb begin
    w_ctrl   = '0;
    w_alu_op = AluOpNone;
    case (r_state)
      StFetch: begin
        w_ctrl.ir_write  = 1'b1;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.alu_src_b = SrcBFour;
        w_ctrl.pc_src    = PcSrcAluResult;
        w_alu_op         = AluOpAdd;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut.
        w_ctrl.alu_src_b = SrcBSignExt2;
        w_alu_op         = AluOpAdd;
      end
      StMemAdr: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SrcBSignExt;
        w_alu_op         = AluOpAdd;
      end
      // Memory states keep recomputing the address since ALUOut reloads
      // every cycle, and hold IorD since read data is not registered.
      StMemRead: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SrcBSignExt;
        w_ctrl.iord      = 1'b1;
        w_alu_op         = AluOpAdd;
      end
      StMemWb: begin
        w_ctrl.alu_src_a  = 1'b1;
        w_ctrl.alu_src_b  = SrcBSignExt;
        w_ctrl.iord       = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_alu_op          = AluOpAdd;
      end
      StMemWrite: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SrcBSignExt;
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_alu_op         = AluOpAdd;
      end
      StExecute: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SrcBRt;
        w_alu_op         = AluOpFunct;
      end
      StAluWb: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      StBranch: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SrcBRt;
        w_ctrl.branch    = 1'b1;
        w_ctrl.pc_src    = PcSrcAluOut;
        w_alu_op         = AluOpSub;
      end
`ifdef MIPS_FSM_ADDI_EN
      StAddiExec: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SrcBSignExt;
        w_alu_op         = AluOpAdd;
      end
      StAddiWb: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SrcBSignExt;
        w_ctrl.reg_write = 1'b1;
        w_alu_op         = AluOpAdd;
      end
`endif
      StJump: begin
        w_ctrl.pc_src   = PcSrcJump;
        w_ctrl.pc_write = 1'b1;
      end
      default: begin
        w_ctrl   = '0;
        w_alu_op = AluOpNone;
      end
    endcase
  end

  mips_alu_dec u_alu_dec (
    .alu_op     (w_alu_op),
    .funct      (bus.funct),
    .ALUControl (w_alu_control)
  );

  assign bus.IorD       = w_ctrl.iord;
  assign bus.MemWrite   = w_ctrl.mem_write;
  assign bus.MemtoReg   = w_ctrl.mem_to_reg;
  assign bus.IRWrite    = w_ctrl.ir_write;
  assign bus.PCWrite    = w_ctrl.pc_write;
  assign bus.RegWrite   = w_ctrl.reg_write;
  assign bus.RegDst     = w_ctrl.reg_dst;
  assign bus.Branch     = w_ctrl.branch;
  assign bus.ALUSrcA    = w_ctrl.alu_src_a;
  assign bus.PCSrc      = w_ctrl.pc_src;
  assign bus.ALUSrcB    = w_ctrl.alu_src_b;
  assign bus.ALUControl = w_alu_control;
  assign bus.state      = r_state;
  assign bus.illegal_op = w_illegal;

endmodule

// File: doc/mips_main_fsm.md
MIPS_MAIN_FSM -- requirements
Module: mips_main_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: opcode  in  6  instr[31:26] from instruction register; funct  in  6  instr[5:0].
REQ-004 SHALL have outputs, 1 bit each: IorD, MemWrite, MemtoReg, IRWrite, PCWrite, RegWrite, RegDst, Branch, ALUSrcA.
REQ-005 SHALL have outputs: PCSrc 2 (00 ALUResult, 01 ALUOut, 10 jump target); ALUSrcB 2 (00 rt, 01 const 4, 10 signext, 11 signext<<2); ALUControl 3 (010 add, 110 sub, 000 and, 001 or, 111 slt).
REQ-006 SHALL have outputs: state 4 (current state, debug); illegal_op 1 (unsupported opcode flag).

Function
REQ-007 SHALL be a Moore FSM: every control output is a function of the registered state only, except ALUControl in EXECUTE (also a function of funct).
REQ-008 SHALL use states and encodings FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11; codes 12-15 SHALL return to FETCH on the next edge.
REQ-009 SHALL use transitions FETCH->DECODE; MEMREAD->MEMWB; MEMWRITE, MEMWB, ALUWB, BRANCH, ADDIWB, JUMP->FETCH; EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
REQ-010 SHALL decode opcode in DECODE: 100011/101011->MEMADR; 000000->EXECUTE; 000100->BRANCH; 001000->ADDIEXEC; 000010->JUMP; any other->FETCH.
REQ-011 SHALL leave MEMADR for MEMREAD when opcode=100011 and for MEMWRITE when opcode=101011.
REQ-012 SHALL drive in FETCH: IorD=0, IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00.
REQ-013 SHALL drive in DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=add, so ALUOut holds the branch target.
REQ-014 SHALL drive in MEMADR, MEMREAD, MEMWB and MEMWRITE: ALUSrcA=1, ALUSrcB=10, ALUControl=add, because ALUOut reloads every cycle and must keep the address.
REQ-015 SHALL additionally drive IorD=1 in MEMREAD, MEMWB and MEMWRITE, because read data is unregistered; MEMWB SHALL also drive RegDst=0, MemtoReg=1, RegWrite=1; MEMWRITE SHALL also drive MemWrite=1.
REQ-016 SHALL drive in EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other add.
REQ-017 SHALL drive in ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
REQ-018 SHALL drive in BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=sub, Branch=1, PCSrc=01, PCWrite=0.
REQ-019 SHALL drive in ADDIEXEC: ALUSrcA=1, ALUSrcB=10, add; in ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, and hold the ADDIEXEC ALU selects.
REQ-020 SHALL drive in JUMP: PCSrc=10, PCWrite=1.
REQ-021 SHALL drive every output not listed for a state to 0, including MemWrite, RegWrite, IRWrite, PCWrite and Branch.
REQ-022 SHALL assert illegal_op for exactly the DECODE cycle whose opcode takes the "any other" path.
REQ-023 SHALL give latencies of 5 cycles for lw; 4 cycles for sw, R-type and addi; 3 cycles for beq and j.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, load FETCH regardless of the current state, including mid-instruction; outputs SHALL then take FETCH values, with MemWrite=RegWrite=illegal_op=0.

Configuration
REQ-025 SHALL, with MIPS_FSM_ADDI_EN defined, implement ADDIEXEC and ADDIWB as above.
REQ-026 SHALL, with MIPS_FSM_ADDI_EN undefined, omit both addi states and treat opcode 001000 as an illegal opcode (DECODE->FETCH, illegal_op=1).

Structure
REQ-027 SHALL take the state encodings, opcode constants, funct constants, ALUControl codes and ALU-op class codes (00 add, 01 sub, 10 funct) from a shared package mips_pkg.
REQ-028 SHALL place funct-to-ALUControl decoding in sub-module mips_alu_dec, with inputs alu_op[1:0] and funct[5:0] and output ALUControl[2:0].

Verification
REQ-029 SHALL cover: rst=1 for 2 cycles, then 0 -> state=0, IRWrite=1, PCWrite=1, ALUSrcB=01.
REQ-030 SHALL cover: opcode=100011 -> states 0,1,2,3,4,0; in state 4, IorD=1, MemtoReg=1, RegWrite=1.
REQ-031 SHALL cover: opcode=000000 with funct=100010, then funct=101010 -> states 0,1,6,7,0; ALUControl=110 and then 111 in state 6.
REQ-032 SHALL cover: opcode=000100 -> states 0,1,8,0; in state 8, Branch=1, PCSrc=01, ALUControl=110, PCWrite=0.
REQ-033 SHALL cover: opcode=001000 -> states 0,1,9,10,0 with MIPS_FSM_ADDI_EN defined; states 0,1,0 with illegal_op=1 in state 1 when it is undefined.
REQ-034 SHALL cover: rst=1 during state 3 of lw -> state=0 on the next edge, and MemWrite=RegWrite=0 thereafter.
